// File: rtl/stim_pkg.sv
// Shared types and word-layout helpers for the stimulus sequencer.
// Optional feature macro: STIM_HOLD_EN (per-entry hold counts).
package stim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} stim_state_t;

`ifdef STIM_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  // Stored word is {hold, vec} with hold enabled, plain vec otherwise.
  function automatic int word_w(input int vec_w, input int hold_w);
    return vec_w + (HOLD_EN ? hold_w : 0);
  endfunction

  function automatic int hold_lsb(input int vec_w);
    return vec_w;
  endfunction

endpackage

// File: rtl/stim_ram.sv
// Stimulus vector memory: synchronous write, asynchronous read, never reset.
module stim_ram #(
  parameter int WORD_W = 3,
  parameter int DEPTH  = 11,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stim_sequencer.sv
// Loadable stimulus playback engine with start/stop/loop control.
// Optional feature macro: STIM_HOLD_EN adds a per-entry hold count.
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int VEC_W  = 3,
  parameter int DEPTH  = 11,
  parameter int HOLD_W = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   wr_en,
  input  logic [ADDR_W-1:0]                      wr_addr,
  input  logic [word_w(VEC_W, HOLD_W)-1:0]       wr_data,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   loop,
  input  logic [ADDR_W-1:0]                      last_addr,
  output logic [VEC_W-1:0]                       vec,
  output logic                                   obs,
  output logic [ADDR_W-1:0]                      pc,
  output logic                                   step,
  output logic                                   busy,
  output logic                                   done
);

  localparam int WORD_W = word_w(VEC_W, HOLD_W);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  stim_state_t       state;
  logic [ADDR_W-1:0] last_eff;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic [VEC_W-1:0]  rd_vec;
  logic              we;
  logic              at_last;
  logic              hold_zero;

  assign last_eff = ({1'b0, last_addr} >= DEPTH_X) ? MAX_ADDR : last_addr;
  assign at_last  = (pc >= last_eff);
  assign we       = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_X);
  // Read address is the entry that the next advance (or start) will load.
  assign rd_addr  = (state == RUN && !at_last) ? pc + ADDR_W'(1) : '0;
  assign rd_vec   = rd_data[VEC_W-1:0];
  assign obs      = vec[VEC_W-1];

  stim_ram #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clock   (clock),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef STIM_HOLD_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] rd_hold;
  assign rd_hold   = rd_data[hold_lsb(VEC_W) +: HOLD_W];
  assign hold_zero = (hold_cnt == '0);

  // Counter reloads whenever a new entry is applied, else counts down to 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (stop) begin
      hold_cnt <= '0;
    end else if (state == IDLE && start) begin
      hold_cnt <= rd_hold;
    end else if (state == RUN) begin
      if (!hold_zero)                 hold_cnt <= hold_cnt - HOLD_W'(1);
      else if (!at_last || loop)      hold_cnt <= rd_hold;
    end
  end
`else
  assign hold_zero = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      vec   <= '0;
      pc    <= '0;
      step  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      vec   <= '0;
      pc    <= '0;
      step  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          step <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            vec   <= rd_vec;
            pc    <= '0;
            step  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          done <= 1'b0;
          if (!hold_zero) begin
            step <= 1'b0;
          end else if (!at_last) begin
            pc   <= pc + ADDR_W'(1);
            vec  <= rd_vec;
            step <= 1'b1;
          end else if (loop) begin
            pc   <= '0;
            vec  <= rd_vec;
            step <= 1'b1;
          end else begin
            state <= FIN;
            step  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          step  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          step  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed self-checking bench for stim_sequencer (default and STIM_HOLD_EN builds).
module tb_stim_sequencer;

  localparam int VEC_W  = 3;
  localparam int DEPTH  = 11;
  localparam int HOLD_W = 4;
  localparam int ADDR_W = 4;
`ifdef STIM_HOLD_EN
  localparam int WORD_W = VEC_W + HOLD_W;
`else
  localparam int WORD_W = VEC_W;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              start, stop, loop;
  logic [ADDR_W-1:0] last_addr;
  logic [VEC_W-1:0]  vec;
  logic              obs;
  logic [ADDR_W-1:0] pc;
  logic              step, busy, done;

  int errors = 0;
  int checks = 0;

  stim_sequencer #(.VEC_W(VEC_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .stop(stop), .loop(loop),
    .last_addr(last_addr), .vec(vec), .obs(obs), .pc(pc), .step(step),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Checks vec/obs/pc/step/busy/done together after an edge.
  task automatic check_out(input string tag, input logic [2:0] v, input logic [3:0] p,
                           input logic s, input logic b, input logic d);
    check({tag, ".vec"},  32'(vec),  32'(v));
    check({tag, ".obs"},  32'(obs),  32'(v[2]));
    check({tag, ".pc"},   32'(pc),   32'(p));
    check({tag, ".step"}, 32'(step), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic write_word(input logic [3:0] a, input logic [2:0] v, input logic [3:0] h);
    wr_en   = 1'b1;
    wr_addr = a;
`ifdef STIM_HOLD_EN
    wr_data = {h, v};
`else
    wr_data = v;
    if (h != 4'd0) $display("note: hold ignored in this build");
`endif
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_basic();
    write_word(4'd0, 3'b001, 4'd0);
    write_word(4'd1, 3'b010, 4'd0);
    write_word(4'd2, 3'b100, 4'd0);
    write_word(4'd3, 3'b111, 4'd0);
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; last_addr = '0;
    #23;
    check_out("reset", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();

    // Basic playback, 4 entries, no loop
    load_basic();
    write_word(4'd12, 3'b110, 4'd0);
    last_addr = 4'd3; loop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check_out("basic0", 3'b001, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(); check_out("basic1", 3'b010, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); check_out("basic2", 3'b100, 4'd2, 1'b1, 1'b1, 1'b0);
    tick(); check_out("basic3", 3'b111, 4'd3, 1'b1, 1'b1, 1'b0);
    tick(); check_out("basic_done", 3'b111, 4'd3, 1'b0, 1'b0, 1'b1);
    tick(); check_out("basic_idle", 3'b111, 4'd3, 1'b0, 1'b0, 1'b0);

    // Out-of-range last_addr clamps to DEPTH-1; entry 10 is never written but pc must stop there
    last_addr = 4'd15;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    check("clamp.pc",   32'(pc),   32'd10);
    check("clamp.busy", 32'(busy), 32'd1);
    tick();
    check("clamp.done", 32'(done), 32'd1);
    tick();

`ifdef STIM_HOLD_EN
    // Hold counts: entry0 hold 2, entry1 hold 0
    write_word(4'd0, 3'b101, 4'd2);
    write_word(4'd1, 3'b011, 4'd0);
    last_addr = 4'd1;
    start = 1'b1; tick(); start = 1'b0;
    check_out("hold0a", 3'b101, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(); check_out("hold0b", 3'b101, 4'd0, 1'b0, 1'b1, 1'b0);
    tick(); check_out("hold0c", 3'b101, 4'd0, 1'b0, 1'b1, 1'b0);
    tick(); check_out("hold1",  3'b011, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); check_out("hold_done", 3'b011, 4'd1, 1'b0, 1'b0, 1'b1);
    tick();
`endif

    // Loop mode over two entries, then stop
    write_word(4'd0, 3'b001, 4'd0);
    write_word(4'd1, 3'b010, 4'd0);
    last_addr = 4'd1; loop = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check_out("loop_a", 3'b001, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(); check_out("loop_b", 3'b010, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); check_out("loop_c", 3'b001, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(); check_out("loop_d", 3'b010, 4'd1, 1'b1, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    check_out("stop", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); check_out("stop_after", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    loop = 1'b0;

    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_out("start_stop", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); check_out("start_stop2", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);

    // start and write during RUN are ignored
    load_basic();
    last_addr = 4'd3;
    start = 1'b1; tick(); start = 1'b0;
    check_out("ign0", 3'b001, 4'd0, 1'b1, 1'b1, 1'b0);
    start = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = '0; wr_data[2:0] = 3'b110;
    tick(); start = 1'b0; wr_en = 1'b0;
    check_out("ign1", 3'b010, 4'd1, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    tick(); check_out("ign_done", 3'b111, 4'd3, 1'b0, 1'b0, 1'b1);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    check_out("replay0", 3'b001, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    tick(); check_out("pre_reset", 3'b100, 4'd2, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-run
    #2 reset_n = 1'b0;
    #1 check_out("async_reset", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    #3 reset_n = 1'b1;
    tick(); check_out("post_reset", 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    check_out("rst_replay0", 3'b001, 4'd0, 1'b1, 1'b1, 1'b0);
    tick(); check_out("rst_replay1", 3'b010, 4'd1, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
